// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the UART transmitter: buffers CPU writes and hands bytes over
// one at a time through a txWe/txBusy handshake (txBusy is synchronized first).
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    wrData,
  input  logic          wrEn,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    txData,
  output logic          txWe,
  input  logic          txBusy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  logic [7:0]    r_tx_data;
  logic          r_busy_meta;
  logic          r_busy_s;
  state_t        r_state;

  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [AW:0]   w_count_next;
  state_t        w_state_next;

  // flush outranks everything; full/empty come from registered state, never this cycle's push
  assign w_push = wrEn && !r_full && !flush;
  assign w_drop = wrEn &&  r_full && !flush;
  assign w_pop  = (r_state == ST_IDLE) && !r_empty && !r_busy_s && !flush;

  // Next occupancy from push/pop/flush
  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_ONE;
    end else begin
      w_count_next = r_count;
    end
  end

  // Storage array write port
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wp] <= wrData;
    end
  end

  // Pointers, occupancy, status flags and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_FULL);
      r_empty <= (w_count_next == '0);
      if (flush) begin
        r_wp       <= '0;
        r_rp       <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_wp <= r_wp + PTR_ONE;
        if (w_pop)  r_rp <= r_rp + PTR_ONE;
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Two-flop synchronizer for the transmitter busy flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy_meta <= 1'b0;
      r_busy_s    <= 1'b0;
    end else begin
      r_busy_meta <= txBusy;
      r_busy_s    <= r_busy_meta;
    end
  end

  // Presented byte only changes when a pop launches a new request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_data <= 8'h00;
    end else if (w_pop) begin
      r_tx_data <= r_mem[r_rp];
    end
  end

  // Handshake state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake next-state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) w_state_next = ST_REQ;
        else       w_state_next = ST_IDLE;
      end
      ST_REQ: begin
        if (r_busy_s) w_state_next = ST_DRAIN;
        else          w_state_next = ST_REQ;
      end
      ST_DRAIN: begin
        if (!r_busy_s) w_state_next = ST_IDLE;
        else           w_state_next = ST_DRAIN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign txData   = r_tx_data;
  assign txWe     = (r_state == ST_REQ);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a monitor
// checks each new transmit request against the queue; a simple transmitter model drives txBusy.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock, reset, wrEn, flush, txBusy;
  logic [7:0]    wrData, txData;
  logic          full, empty, overflow, txWe;
  logic [AW:0]   count;

  logic          model_busy, force_busy, xmit_en;
  int            busy_delay, busy_len;
  int            n_cmp, n_err;
  logic [7:0]    sb [$];
  logic          prev_we;
  logic [7:0]    prev_data;
  logic          saw_we = 1'b0;
  int            guard;
  logic          stall_to;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .wrData(wrData), .wrEn(wrEn), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .txData(txData), .txWe(txWe), .txBusy(txBusy)
  );

  assign txBusy = model_busy | force_busy;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: busy rises busy_delay cycles after a request, lasts busy_len cycles
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (txWe === 1'b1 && xmit_en) begin
        repeat (busy_delay) @(negedge clock);
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clock);
        model_busy = 1'b0;
      end
    end
  end

  // Monitor: each new request must carry the oldest expected byte, held stable
  initial begin
    prev_we   = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clock);
      if (txWe === 1'b1) saw_we = 1'b1;
      if (txWe === 1'b1 && prev_we !== 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_txWe: got request with txData %0h expected none", txData);
        end else begin
          chk("tx_order", txData, sb.pop_front());
        end
      end else if (txWe === 1'b1) begin
        chk("tx_stable", txData, prev_data);
      end
      prev_we   = txWe;
      prev_data = txData;
    end
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: got no end of test expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] d, input bit expect_tx);
    wrData = d;
    wrEn   = 1'b1;
    if (expect_tx) sb.push_back(d);
    @(negedge clock);
    wrEn = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (i < 4000 && !(sb.size() == 0 && empty === 1'b1 && txWe === 1'b0 && txBusy === 1'b0)) begin
      @(negedge clock);
      i++;
    end
    chk(name, (i < 4000), 1);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0; wrEn = 1'b0; flush = 1'b0; wrData = 8'h00;
    force_busy = 1'b0; xmit_en = 1'b1; busy_delay = 4; busy_len = 100;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_txData", txData, 8'h00);
    chk("rst_txWe", txWe, 0);

    // Single byte with exact handshake timing
    push(8'hA5, 1'b1);
    chk("single_count1", count, 1);
    chk("single_empty0", empty, 0);
    chk("single_we_early", txWe, 0);
    @(negedge clock);
    chk("single_we_rise", txWe, 1);
    chk("single_data", txData, 8'hA5);
    chk("single_count0", count, 0);
    chk("single_empty1", empty, 1);
    repeat (6) @(negedge clock);
    chk("single_busy_seen", txBusy, 1);
    chk("single_we_held", txWe, 1);
    @(negedge clock);
    chk("single_we_drop", txWe, 0);
    drain("single_drain");

    // Burst ordering: 00..0F back-to-back, one popped immediately
    busy_delay = 1; busy_len = 20;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("burst_count15", count, 15);
    chk("burst_full0", full, 0);
    drain("burst_drain");
    chk("burst_empty", empty, 1);
    chk("burst_count0", count, 0);

    // Overflow with a byte parked in REQ, then flush
    xmit_en = 1'b0;
    push(8'hC3, 1'b1);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b0);
    chk("ovf_full", full, 1);
    chk("ovf_count16", count, 16);
    chk("ovf_before", overflow, 0);
    push(8'hFF, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count_hold", count, 16);
    @(negedge clock);
    chk("ovf_sticky", overflow, 1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_overflow", overflow, 0);
    chk("flush_empty", empty, 1);
    chk("flush_full", full, 0);
    chk("flush_inflight_we", txWe, 1);
    chk("flush_inflight_data", txData, 8'hC3);
    busy_delay = 2; busy_len = 10; xmit_en = 1'b1;
    drain("flush_drain");

    // Push during the pop cycle with count=3, then a 40-byte stream that wraps
    busy_delay = 1; busy_len = 5;
    force_busy = 1'b1;
    repeat (3) @(negedge clock);
    push(8'h40, 1'b1); push(8'h41, 1'b1); push(8'h42, 1'b1);
    chk("pp_count3", count, 3);
    chk("pp_no_we", txWe, 0);
    force_busy = 1'b0;
    repeat (2) @(negedge clock);
    push(8'h43, 1'b1);
    chk("pp_count_hold", count, 3);
    chk("pp_pop_we", txWe, 1);
    stall_to = 1'b0;
    for (int i = 4; i < 40; i++) begin
      guard = 0;
      while (full === 1'b1 && guard < 2000) begin
        @(negedge clock);
        guard++;
      end
      if (guard >= 2000) stall_to = 1'b1;
      push(8'(i * 37 + 11), 1'b1);
    end
    chk("stream_no_stall", stall_to, 0);
    drain("stream_drain");
    chk("stream_count0", count, 0);
    chk("stream_overflow", overflow, 0);

    // Flush and write in the same cycle
    saw_we = 1'b0;
    wrData = 8'h77; wrEn = 1'b1; flush = 1'b1;
    @(negedge clock);
    wrEn = 1'b0; flush = 1'b0;
    chk("flushwr_count", count, 0);
    chk("flushwr_empty", empty, 1);
    chk("flushwr_overflow", overflow, 0);
    repeat (10) @(negedge clock);
    chk("flushwr_no_tx", saw_we, 0);

    // Asynchronous reset mid-request with 5 bytes queued
    xmit_en = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 1'b1);
    chk("rstmid_count5", count, 5);
    chk("rstmid_we", txWe, 1);
    reset = 1'b0;
    #1;
    chk("rstmid_we_drop", txWe, 0);
    chk("rstmid_count0", count, 0);
    chk("rstmid_empty", empty, 1);
    chk("rstmid_overflow", overflow, 0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    saw_we = 1'b0;
    repeat (10) @(negedge clock);
    chk("rstmid_no_we", saw_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
